mac_dot_sequencer: RTL and testbench

- Upstream operand feeder for the 3x3 MAC multiplier.
- Buffers incoming (A,B) operand pairs in a small FIFO and streams them into the MAC as fixed-length dot-product frames of N_TERMS terms.
- Clears the MAC between frames, then captures the final MAC_OUT into a result register with a valid/ready handshake.
- Owns all MAC control: drives the MAC's SCLR, LOAD, A and B inputs.

---
 rtl/mac_dot_sequencer.sv | 142 ++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// mac_dot_sequencer
//   Operand feeder for the MAC multiplier. Buffers (A,B) pairs in a small
//   FIFO, streams them into the MAC as frames of N_TERMS terms, clears the
//   MAC between frames and captures each final dot product into a result
//   register with a valid/ready handshake.
//
// Ports
//   SYS_CLOCK              system clock, rising edge
//   RESET                  asynchronous active-high reset
//   IN_VALID/IN_READY      operand pair handshake (IN_READY = !full)
//   IN_A, IN_B             operand pair
//   MAC_SCLR, MAC_LOAD     MAC control (SCLR dominates LOAD inside the MAC)
//   MAC_A, MAC_B           MAC operands, forced to 0 when MAC_LOAD=0
//   MAC_OUT                MAC accumulator value
//   RES_VALID/RES_READY    result handshake
//   RES_DATA               captured dot product (mod 2^(2*WIDTH))
// ---------------------------------------------------------------------------
module mac_dot_sequencer #(
    parameter int WIDTH   = 3,
    parameter int DEPTH   = 4,
    parameter int N_TERMS = 4
) (
    input  logic               SYS_CLOCK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   IN_A,
    input  logic [WIDTH-1:0]   IN_B,
    output logic               MAC_SCLR,
    output logic               MAC_LOAD,
    output logic [WIDTH-1:0]   MAC_A,
    output logic [WIDTH-1:0]   MAC_B,
    input  logic [2*WIDTH-1:0] MAC_OUT,
    output logic               RES_VALID,
    input  logic               RES_READY,
    output logic [2*WIDTH-1:0] RES_DATA
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(N_TERMS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_TERMS - 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic               r_res_valid;
    logic [2*WIDTH-1:0] r_res_data;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // with all DEPTH entries usable.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // Readiness ignores a same-cycle pop: a full FIFO never accepts.
    assign w_push  = IN_VALID && !w_full;
    assign w_pop   = (r_state == ST_ACCUM) && !w_empty;
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    assign IN_READY  = !w_full;
    assign MAC_SCLR  = (r_state == ST_IDLE);
    assign MAC_LOAD  = w_pop;
    assign MAC_A     = w_pop ? w_head[2*WIDTH-1:WIDTH] : '0;
    assign MAC_B     = w_pop ? w_head[WIDTH-1:0]       : '0;
    assign RES_VALID = r_res_valid;
    assign RES_DATA  = r_res_data;

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge SYS_CLOCK) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {IN_A, IN_B};
        end
    end

    always_ff @(posedge SYS_CLOCK or posedge RESET) begin
        if (RESET) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge SYS_CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                // MAC is cleared on every edge spent here, so each frame
                // starts from zero.
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_ACCUM;
                end
                // An empty FIFO is a bubble: no load, count holds.
                ST_ACCUM: begin
                    if (w_pop) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                // MAC_OUT already reflects the last load here.
                ST_DRAIN: begin
                    r_res_data  <= MAC_OUT;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (RES_READY) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_sequencer
//   Drives mac_dot_sequencer against a cycle-accurate MAC model. Expected
//   dot products come from a frame-level model: sum of a*b over every
//   N_TERMS accepted pairs, mod 64. A negedge monitor records loads,
//   popped operands, handshakes and result stability.
// ---------------------------------------------------------------------------
module tb_mac_dot_sequencer;

    localparam int W = 3;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         sclr, load;
    logic [W-1:0] mac_a, mac_b;
    logic [5:0]   mac_acc;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [5:0]   res_data;

    mac_dot_sequencer #(.WIDTH(W), .DEPTH(4), .N_TERMS(N)) dut (
        .SYS_CLOCK(clk), .RESET(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_A(in_a), .IN_B(in_b),
        .MAC_SCLR(sclr), .MAC_LOAD(load), .MAC_A(mac_a), .MAC_B(mac_b),
        .MAC_OUT(mac_acc),
        .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data)
    );

    always #5 clk = ~clk;

    // MAC: SCLR dominates LOAD, result visible after the edge.
    always @(posedge clk) begin
        if (sclr)      mac_acc <= 6'd0;
        else if (load) mac_acc <= mac_acc + 6'(mac_a) * 6'(mac_b);
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard / frame model
    logic [5:0] pushed_q[$];
    logic [5:0] popped_q[$];
    logic [5:0] exp_q[$];
    int         m_acc = 0;
    int         m_terms = 0;

    // monitor state
    int         load_cnt, load_runs, res_hi_cnt, zero_viol, stab_viol;
    int         load_cycs[$];
    int         res_cycs[$];
    int         hs_cycs[$];
    logic [5:0] res_q[$];
    bit         prev_load = 0;
    bit         prev_pend = 0;
    logic [5:0] prev_data = '0;
    bit         rand_ready = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (load) begin
                load_cnt++;
                load_cycs.push_back(cyc);
                popped_q.push_back({mac_a, mac_b});
                if (!prev_load) load_runs++;
            end else if (mac_a != 0 || mac_b != 0) begin
                zero_viol++;
            end
            if (prev_pend && (!res_valid || res_data !== prev_data)) stab_viol++;
            if (res_valid) begin
                res_hi_cnt++;
                res_cycs.push_back(cyc);
            end
            if (res_valid && res_ready) begin
                res_q.push_back(res_data);
                hs_cycs.push_back(cyc);
            end
            prev_pend = res_valid && !res_ready;
            prev_data = res_data;
            prev_load = load;
        end else begin
            prev_load = 0;
            prev_pend = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    end

    task automatic clear_mon();
        load_cnt = 0; load_runs = 0; res_hi_cnt = 0; zero_viol = 0; stab_viol = 0;
        load_cycs.delete(); res_cycs.delete(); hs_cycs.delete(); res_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        bit ok = 0;
        waited = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!ok && waited < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (!ok) waited++;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL push_timeout: pair (%0d,%0d) not accepted in 200 cycles", a, b);
        end else begin
            pushed_q.push_back({a, b});
            m_acc = (m_acc + int'(a) * int'(b)) % 64;
            m_terms++;
            if (m_terms == N) begin
                exp_q.push_back(6'(m_acc));
                m_acc = 0;
                m_terms = 0;
            end
        end
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (res_valid) ok = 1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL valid_timeout: RES_VALID never rose, got 0 expected 1");
        end
    endtask

    task automatic wait_results(input int n);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (res_q.size() >= n) ok = 1;
            else idle(1);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL result_timeout: got %0d results expected %0d", res_q.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid: got %0b expected 0", res_valid); end
        checks++; if (res_data !== 6'd0) begin failures++; $display("FAIL rst_res_data: got %0d expected 0", res_data); end
        checks++; if (sclr !== 1'b1) begin failures++; $display("FAIL rst_sclr: got %0b expected 1", sclr); end
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL rst_load: got %0b expected 0", load); end
        checks++; if (mac_a !== 3'd0 || mac_b !== 3'd0) begin failures++; $display("FAIL rst_mac_ab: got %0d,%0d expected 0,0", mac_a, mac_b); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
        @(posedge clk);
        #3 rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        int w;
        logic [5:0] e;
        clear_mon();
        res_ready = 1'b1;
        push(3'd1, 3'd1, w); push(3'd2, 3'd3, w); push(3'd3, 3'd2, w); push(3'd1, 3'd5, w);
        wait_results(1);
        idle(4);
        e = exp_q.pop_front();
        checks++; if (res_q[0] !== 6'd18) begin failures++; $display("FAIL basic_const: got %0d expected 18", res_q[0]); end
        checks++; if (res_q[0] !== e) begin failures++; $display("FAIL basic_model: got %0d expected %0d", res_q[0], e); end
        checks++; if (load_cnt != 4 || load_runs != 1) begin failures++; $display("FAIL basic_loads: got cnt=%0d runs=%0d expected 4,1", load_cnt, load_runs); end
        checks++; if (res_hi_cnt != 1) begin failures++; $display("FAIL basic_valid_len: got %0d cycles expected 1", res_hi_cnt); end
        checks++; if (res_cycs[0] - load_cycs[3] != 2) begin failures++; $display("FAIL basic_latency: got %0d expected 2", res_cycs[0] - load_cycs[3]); end
        checks++; if (zero_viol != 0) begin failures++; $display("FAIL basic_ab_zero: got %0d violations expected 0", zero_viol); end
    endtask

    task automatic test_gap();
        int w;
        logic [5:0] e;
        clear_mon();
        push(3'd1, 3'd1, w); push(3'd2, 3'd3, w);
        idle(3);
        push(3'd3, 3'd2, w); push(3'd1, 3'd5, w);
        wait_results(1);
        e = exp_q.pop_front();
        checks++; if (res_q[0] !== 6'd18 || res_q[0] !== e) begin failures++; $display("FAIL gap_result: got %0d expected 18 (model %0d)", res_q[0], e); end
        checks++; if (load_cnt != 4 || load_runs != 2) begin failures++; $display("FAIL gap_bubble: got cnt=%0d runs=%0d expected 4,2", load_cnt, load_runs); end
    endtask

    task automatic test_wrap();
        int w;
        logic [5:0] e;
        clear_mon();
        repeat (4) push(3'd7, 3'd7, w);
        repeat (4) push(3'd1, 3'd1, w);
        wait_results(2);
        e = exp_q.pop_front();
        checks++; if (res_q[0] !== 6'd4 || res_q[0] !== e) begin failures++; $display("FAIL wrap_mod: got %0d expected 4 (model %0d)", res_q[0], e); end
        e = exp_q.pop_front();
        checks++; if (res_q[1] !== 6'd4 || res_q[1] !== e) begin failures++; $display("FAIL wrap_cleared: got %0d expected 4 (model %0d)", res_q[1], e); end
    endtask

    task automatic test_backpressure();
        int w, wsum;
        logic [5:0] e;
        clear_mon();
        res_ready = 1'b0;
        repeat (4) push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), w);
        wait_valid();
        e = exp_q[0];
        wsum = 0;
        repeat (4) begin push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), w); wsum += w; end
        checks++; if (wsum != 0) begin failures++; $display("FAIL bp_accept_hold: got %0d stall cycles expected 0", wsum); end
        in_valid = 1'b1; in_a = 3'd5; in_b = 3'd6;
        repeat (3) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full: got in_ready=%0b expected 0", in_ready); end
            checks++; if (res_valid !== 1'b1 || res_data !== e) begin failures++; $display("FAIL bp_hold: got v=%0b d=%0d expected 1,%0d", res_valid, res_data, e); end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        res_ready = 1'b1;
        wait_results(2);
        idle(6);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++; if (res_q[i] !== e) begin failures++; $display("FAIL bp_result%0d: got %0d expected %0d", i, res_q[i], e); end
        end
        checks++; if (load_cycs.size() != 8 || load_cycs[4] != hs_cycs[0] + 2) begin failures++; $display("FAIL bp_restart: got loads=%0d first=%0d expected 8,%0d", load_cycs.size(), load_cycs[4], hs_cycs[0] + 2); end
        checks++; if (stab_viol != 0) begin failures++; $display("FAIL bp_stable: got %0d changes expected 0", stab_viol); end
    endtask

    task automatic test_async_reset();
        int w;
        bit ok = 0;
        clear_mon();
        res_ready = 1'b1;
        repeat (4) push(3'd3, 3'd3, w);
        for (int i = 0; i < 50 && !ok; i++) begin
            if (load_cnt >= 2) ok = 1;
            else idle(1);
        end
        #2 rst = 1'b1;
        #1;
        pushed_q.delete(); popped_q.delete(); exp_q.delete(); m_acc = 0; m_terms = 0;
        checks++; if (!ok) begin failures++; $display("FAIL ar_setup: got %0d loads expected 2", load_cnt); end
        checks++; if (res_valid !== 1'b0 || res_data !== 6'd0) begin failures++; $display("FAIL ar_res: got v=%0b d=%0d expected 0,0", res_valid, res_data); end
        checks++; if (sclr !== 1'b1 || load !== 1'b0) begin failures++; $display("FAIL ar_mac: got sclr=%0b load=%0b expected 1,0", sclr, load); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready: got %0b expected 1", in_ready); end
        idle(2);
        #2 rst = 1'b0;
        idle(1);
        clear_mon();
        repeat (4) push(3'd2, 3'd2, w);
        wait_results(1);
        idle(5);
        checks++; if (res_q.size() != 1 || res_q[0] !== 6'd16 || res_q[0] !== exp_q[0]) begin failures++; $display("FAIL ar_new_frame: got n=%0d d=%0d expected 1,16", res_q.size(), res_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_simul();
        int w, wsum;
        logic [5:0] e;
        clear_mon();
        res_ready = 1'b0;
        repeat (4) push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), w);
        wait_valid();
        repeat (3) push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), w);
        res_ready = 1'b1;
        idle(2);
        // FIFO holds 3 and the sequencer pops every cycle from here on
        wsum = 0;
        repeat (4) begin push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), w); wsum += w; end
        checks++; if (wsum != 0) begin failures++; $display("FAIL simul_ready: got %0d stall cycles expected 0", wsum); end
        push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), w);
        wait_results(3);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++; if (res_q[i] !== e) begin failures++; $display("FAIL simul_result%0d: got %0d expected %0d", i, res_q[i], e); end
        end
    endtask

    task automatic test_random();
        int w, nexp, bad;
        clear_mon();
        rand_ready = 1;
        repeat (6 * N) begin
            push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), w);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 0;
        idle(1);
        res_ready = 1'b1;
        nexp = exp_q.size();
        wait_results(nexp);
        for (int i = 0; i < nexp; i++) begin
            checks++; if (res_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_result%0d: got %0d expected %0d", i, res_q[i], exp_q[i]); end
        end
        exp_q.delete();
        checks++; if (stab_viol != 0 || zero_viol != 0) begin failures++; $display("FAIL rand_protocol: got stab=%0d zero=%0d expected 0,0", stab_viol, zero_viol); end
        bad = 0;
        for (int i = 0; i < pushed_q.size() && i < popped_q.size(); i++)
            if (pushed_q[i] !== popped_q[i]) bad++;
        checks++; if (bad != 0 || pushed_q.size() != popped_q.size()) begin failures++; $display("FAIL fifo_order: got %0d mismatched of %0d/%0d expected 0", bad, popped_q.size(), pushed_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_wrap();
        test_backpressure();
        test_async_reset();
        test_simul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
